// File: rtl/linebuff_nf_window.sv
// NUM_CH parallel line buffers that emit a KSIZE x KSIZE window per accepted raster pixel (LB_STRIDE2_EN: even-origin windows only).
// Latency: 1 cycle; window, coordinates, valid and frame-done are registered after the accepting edge.
// Backpressure: none; every lb_valid_i with lb_en high is consumed, and lb_en low freezes all state.
module linebuff_nf_window #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 1,
    parameter int IMG_COLS   = 32,
    parameter int IMG_ROWS   = 32,
    parameter int KSIZE      = 5,
    parameter int CW         = $clog2(IMG_COLS),
    parameter int RW         = $clog2(IMG_ROWS)
) (
    input  logic                                                  lb_clk,
    input  logic                                                  lb_rst_b,
    input  logic                                                  lb_en,
    input  logic                                                  lb_valid_i,
    input  logic                                                  lb_sof_i,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]                     lb_in_i,
    output logic [NUM_CH-1:0][KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] lb_win_o,
    output logic                                                  lb_win_valid_o,
    output logic [RW-1:0]                                         lb_out_row_o,
    output logic [CW-1:0]                                         lb_out_col_o,
    output logic                                                  lb_frame_done_o
);

    typedef logic [NUM_CH-1:0][KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_K1   = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_K1   = RW'(KSIZE - 1);

    logic          accept;
    logic [RW-1:0] row_cnt, pix_row, out_row, row_q;
    logic [CW-1:0] col_cnt, pix_col, out_col, col_q;
    logic          stride_ok, win_hit, valid_q, done_q;
    win_t          win_q, win_nxt, out_win;

    assign accept  = lb_en & lb_valid_i;
    // sof forces the current pixel to the frame origin regardless of the counters
    assign pix_row = lb_sof_i ? '0 : row_cnt;
    assign pix_col = lb_sof_i ? '0 : col_cnt;
    assign out_row = pix_row - ROW_K1;
    assign out_col = pix_col - COL_K1;

`ifdef LB_STRIDE2_EN
    assign stride_ok = ~out_row[0] & ~out_col[0];
`else
    assign stride_ok = 1'b1;
`endif

    assign win_hit = accept & (pix_row >= ROW_K1) & (pix_col >= COL_K1) & stride_ok;

    always_ff @(posedge lb_clk or negedge lb_rst_b) begin
        if (!lb_rst_b) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            if (pix_col == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
            end else begin
                col_cnt <= pix_col + CW'(1);
                row_cnt <= pix_row;
            end
        end
    end

    // One word per column holds the K-1 previous rows; index 0 is the most recent row.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [KSIZE-2:0][DATA_WIDTH-1:0] line_mem [IMG_COLS];
        logic [KSIZE-1:0][DATA_WIDTH-1:0] col_new;

        assign col_new = {line_mem[pix_col], lb_in_i[ch]};

        always_ff @(posedge lb_clk) begin
            if (accept) begin
                line_mem[pix_col] <= col_new[KSIZE-2:0];
            end
        end

        for (genvar i = 0; i < KSIZE; i++) begin : g_row
            for (genvar j = 0; j < KSIZE - 1; j++) begin : g_col
                assign win_nxt[ch][i][j] = win_q[ch][i][j+1];
            end
            // row 0 of the window is the oldest stored row, row K-1 the live pixel
            assign win_nxt[ch][i][KSIZE-1] = col_new[KSIZE-1-i];
        end
    end

    always_ff @(posedge lb_clk or negedge lb_rst_b) begin
        if (!lb_rst_b) begin
            win_q   <= '0;
            out_win <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            valid_q <= win_hit;
            done_q  <= win_hit & (pix_row == ROW_LAST) & (pix_col == COL_LAST);
            if (accept) begin
                win_q <= win_nxt;
            end
            if (win_hit) begin
                out_win <= win_nxt;
                row_q   <= out_row;
                col_q   <= out_col;
            end
        end
    end

    assign lb_win_o        = out_win;
    assign lb_win_valid_o  = valid_q;
    assign lb_out_row_o    = row_q;
    assign lb_out_col_o    = col_q;
    assign lb_frame_done_o = done_q;

endmodule

// File: tb/tb_linebuff_nf_window.sv
// Directed + randomized bench for linebuff_nf_window, checked against an image-array model of the window rules.
module tb_linebuff_nf_window;

    localparam int DW   = 8;
    localparam int NCH  = 2;
    localparam int COLS = 6;
    localparam int ROWS = 6;
    localparam int K    = 3;
`ifdef LB_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int PER_ROW = (COLS - K) / STRIDE + 1;
    localparam int N_WIN   = ((ROWS - K) / STRIDE + 1) * PER_ROW;
    localparam int N_DONE  = (((ROWS - K) % STRIDE) == 0 && ((COLS - K) % STRIDE) == 0) ? 1 : 0;

    typedef logic [NCH-1:0][K-1:0][K-1:0][DW-1:0] win_t;

    logic                    clk;
    logic                    rst_b;
    logic                    lb_en;
    logic                    lb_valid;
    logic                    lb_sof;
    logic [NCH-1:0][DW-1:0]  lb_in;
    win_t                    lb_win;
    logic                    lb_win_valid;
    logic [2:0]              lb_out_row;
    logic [2:0]              lb_out_col;
    logic                    lb_frame_done;

    linebuff_nf_window #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .IMG_COLS(COLS), .IMG_ROWS(ROWS), .KSIZE(K)
    ) dut (
        .lb_clk          (clk),
        .lb_rst_b        (rst_b),
        .lb_en           (lb_en),
        .lb_valid_i      (lb_valid),
        .lb_sof_i        (lb_sof),
        .lb_in_i         (lb_in),
        .lb_win_o        (lb_win),
        .lb_win_valid_o  (lb_win_valid),
        .lb_out_row_o    (lb_out_row),
        .lb_out_col_o    (lb_out_col),
        .lb_frame_done_o (lb_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: last pixel accepted at each (ch, r, c) of the current frame
    int         img [NCH][ROWS][COLS];
    int         m_r, m_c;
    logic       e_valid, e_done;
    logic [2:0] e_row, e_col;
    win_t       e_win;

    int         f_acc, f_valids, f_dones, f_first_acc;
    win_t       f_first_win, f_done_win;
    logic [5:0] f_first_rc, f_done_rc;
    win_t       f_wins [16];

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic win_t mk_win(input int b);
        win_t w;
        for (int ch = 0; ch < NCH; ch++)
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    w[ch][i][j] = 8'(b + 100 * ch + COLS * i + j);
        return w;
    endfunction

    task automatic begin_frame();
        f_acc = 0; f_valids = 0; f_dones = 0; f_first_acc = -1;
        f_first_win = '0; f_done_win = '0; f_first_rc = '0; f_done_rc = '0;
    endtask

    task automatic step(input logic en, input logic vld, input logic sof, input int v0, input int v1);
        int pr, pc;
        @(negedge clk);
        lb_en = en; lb_valid = vld; lb_sof = sof;
        lb_in[0] = 8'(v0); lb_in[1] = 8'(v1);
        @(posedge clk);
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (en && vld) begin
            pr = sof ? 0 : m_r;
            pc = sof ? 0 : m_c;
            img[0][pr][pc] = v0 & 255;
            img[1][pr][pc] = v1 & 255;
            f_acc++;
            if (pr >= K - 1 && pc >= K - 1 &&
                ((pr - (K - 1)) % STRIDE) == 0 && ((pc - (K - 1)) % STRIDE) == 0) begin
                e_valid = 1'b1;
                e_row = 3'(pr - (K - 1));
                e_col = 3'(pc - (K - 1));
                for (int ch = 0; ch < NCH; ch++)
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            e_win[ch][i][j] = 8'(img[ch][pr - (K - 1) + i][pc - (K - 1) + j]);
                e_done = (pr == ROWS - 1) && (pc == COLS - 1);
            end
            m_c = (pc == COLS - 1) ? 0 : pc + 1;
            m_r = (pc == COLS - 1) ? ((pr == ROWS - 1) ? 0 : pr + 1) : pr;
        end
        #1;
        chk("valid", lb_win_valid, e_valid);
        chk("frame_done", lb_frame_done, e_done);
        chk("out_row", lb_out_row, e_row);
        chk("out_col", lb_out_col, e_col);
        chk("window", lb_win, e_win);
        if (lb_win_valid) begin
            if (f_valids == 0) begin
                f_first_acc = f_acc;
                f_first_win = lb_win;
                f_first_rc  = {lb_out_row, lb_out_col};
            end
            if (f_valids < 16) f_wins[f_valids] = lb_win;
            f_valids++;
        end
        if (lb_frame_done) begin
            f_dones++;
            f_done_win = lb_win;
            f_done_rc  = {lb_out_row, lb_out_col};
        end
    endtask

    task automatic frame_chk(input string tag, input int base);
        chk({tag, "_first_accept"}, f_first_acc, 15);
        chk({tag, "_first_win"}, f_first_win, mk_win(base));
        chk({tag, "_first_coord"}, f_first_rc, 6'd0);
        chk({tag, "_valid_count"}, f_valids, N_WIN);
        chk({tag, "_done_count"}, f_dones, N_DONE);
        for (int k = 0; k < N_WIN && k < f_valids; k++)
            chk({tag, "_win_seq"}, f_wins[k],
                mk_win(base + (k / PER_ROW) * STRIDE * COLS + (k % PER_ROW) * STRIDE));
`ifndef LB_STRIDE2_EN
        chk({tag, "_done_win"}, f_done_win, mk_win(base + (ROWS - K) * COLS + (COLS - K)));
        chk({tag, "_done_coord"}, f_done_rc, {3'(ROWS - K), 3'(COLS - K)});
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, lb_win_valid, 1'b0);
        chk({tag, "_done"}, lb_frame_done, 1'b0);
        chk({tag, "_row"}, lb_out_row, 3'd0);
        chk({tag, "_col"}, lb_out_col, 3'd0);
        chk({tag, "_win"}, lb_win, '0);
    endtask

    initial begin
        for (int ch = 0; ch < NCH; ch++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    img[ch][r][c] = 0;
        m_r = 0; m_c = 0;
        e_valid = 1'b0; e_done = 1'b0; e_row = '0; e_col = '0; e_win = '0;
        rst_b = 1'b0; lb_en = 1'b0; lb_valid = 1'b0; lb_sof = 1'b0; lb_in = '0;
        begin_frame();

        // reset state
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_b = 1'b1;

        // frame A: continuous raster
        begin_frame();
        for (int idx = 0; idx < ROWS * COLS; idx++)
            step(1'b1, 1'b1, idx == 0, idx, idx + 100);
        frame_chk("frameA", 0);

        // frame B: enable low for 3 cycles at pixel 9, valid gaps before pixels 20-21
        begin_frame();
        for (int idx = 0; idx < ROWS * COLS; idx++) begin
            if (idx == 9)
                for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, int'($urandom), int'($urandom));
            if (idx == 20 || idx == 21)
                step(1'b1, 1'b0, 1'b0, int'($urandom), int'($urandom));
            step(1'b1, 1'b1, idx == 0, idx, idx + 100);
        end
        frame_chk("frameB", 0);

        // frame C back-to-back, values offset by 50
        begin_frame();
        for (int idx = 0; idx < ROWS * COLS; idx++)
            step(1'b1, 1'b1, idx == 0, idx + 50, idx + 150);
        frame_chk("frameC", 50);

        // sof mid-frame at old pixel 20
        for (int idx = 0; idx < 20; idx++)
            step(1'b1, 1'b1, idx == 0, idx, idx + 100);
        begin_frame();
        for (int idx = 0; idx < ROWS * COLS; idx++)
            step(1'b1, 1'b1, idx == 0, idx, idx + 100);
        frame_chk("midsof", 0);

        // randomized traffic: gaps, enable drops, occasional sof, random pixels
        for (int n = 0; n < 150; n++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        // asynchronous reset between edges, mid-frame after windows were emitted
        for (int idx = 0; idx < 22; idx++)
            step(1'b1, 1'b1, idx == 0, idx, idx + 100);
        #2;
        rst_b = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        e_valid = 1'b0; e_done = 1'b0; e_row = '0; e_col = '0; e_win = '0;
        m_r = 0; m_c = 0;
        lb_en = 1'b0; lb_valid = 1'b0; lb_sof = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        begin_frame();
        for (int idx = 0; idx < ROWS * COLS; idx++)
            step(1'b1, 1'b1, idx == 0, idx, idx + 100);
        frame_chk("post_reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
